// File: rtl/regfile_pipelined_decode_pkg.sv
// Shared types and helpers for the pipelined-decode register file.
// Optional feature macro: REGFILE_WR_FORWARD_EN (write-to-read bypass).
package regfile_pkg;

    // Clear engine state
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Architectural zero register index
    localparam int unsigned REG_ZERO = 0;

    // Address width needed to index n registers
    function automatic int unsigned addr_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_pipelined_decode_if.sv
// Write/read/clear bus of the register file; clock and reset stay plain ports.
interface regfile_pipelined_decode_if
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDR_W   = addr_w(NUM_REGS)
) ();

    logic                ctrl_writeEnable;
    logic [ADDR_W-1:0]   ctrl_writeReg;
    logic [WIDTH-1:0]    data_writeReg;
    logic [ADDR_W-1:0]   ctrl_readRegA;
    logic [ADDR_W-1:0]   ctrl_readRegB;
    logic [WIDTH-1:0]    data_readRegA;
    logic [WIDTH-1:0]    data_readRegB;
    logic                ctrl_clear;
    logic                busy;
    logic [NUM_REGS-1:0] wr_onehot;

    // Datapath side driving requests
    modport master (
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output ctrl_readRegA, ctrl_readRegB, ctrl_clear,
        input  data_readRegA, data_readRegB, busy, wr_onehot
    );

    // Register file side
    modport slave (
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  ctrl_readRegA, ctrl_readRegB, ctrl_clear,
        output data_readRegA, data_readRegB, busy, wr_onehot
    );

endinterface

// File: rtl/regfile_pipelined_decode_decoder_onehot.sv
// Generic binary-to-one-hot decoder (combinational).
module decoder_onehot #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0]       i_addr,
    output logic [(1<<ADDR_W)-1:0]  o_onehot_c
);

    // Single bit set at the addressed position
    always_comb begin
        o_onehot_c         = '0;
        o_onehot_c[i_addr] = 1'b1;
    end

endmodule

// File: rtl/regfile_pipelined_decode.sv
// 1W/2R register file with a registered write-decode stage and a bulk-clear engine.
// Register 0 reads as zero. Optional macro REGFILE_WR_FORWARD_EN bypasses the
// pending write to the read ports one edge earlier.
module regfile_pipelined_decode
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDR_W   = addr_w(NUM_REGS)
) (
    input  logic                        clock,
    input  logic                        ctrl_reset_n,
    regfile_pipelined_decode_if.slave   bus
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [ADDR_W-1:0]   w_clr_cnt_nxt;
    logic                w_sweep;

    logic                w_wr_accept;
    logic [NUM_REGS-1:0] w_dec_onehot;
    logic [NUM_REGS-1:0] r_wr_onehot;
    logic [WIDTH-1:0]    r_data_q;
    logic                r_pending;
    logic [WIDTH-1:0]    r_regs [NUM_REGS];
    logic [WIDTH-1:0]    w_rd_a;
    logic [WIDTH-1:0]    w_rd_b;
`ifdef REGFILE_WR_FORWARD_EN
    logic [ADDR_W-1:0]   r_wr_addr;
`endif

    // A write is taken only when idle and not colliding with a clear request
    assign w_wr_accept = bus.ctrl_writeEnable && (r_state == IDLE) && !bus.ctrl_clear;

    decoder_onehot #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .i_addr     (bus.ctrl_writeReg),
        .o_onehot_c (w_dec_onehot)
    );

    // Clear FSM state, busy flag and sweep counter
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= w_busy_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Clear FSM next state: sweep one register per edge, stop after the last
    always_comb begin
        w_state_nxt   = r_state;
        w_busy_nxt    = r_busy;
        w_clr_cnt_nxt = r_clr_cnt;
        w_sweep       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.ctrl_clear) begin
                    w_state_nxt   = CLEAR;
                    w_busy_nxt    = 1'b1;
                    w_clr_cnt_nxt = '0;
                end
            end
            CLEAR: begin
                w_sweep       = 1'b1;
                w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
                if (r_clr_cnt == ADDR_W'(NUM_REGS - 1)) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Write stage 1: register decoded select and data
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_wr_onehot <= '0;
            r_data_q    <= '0;
            r_pending   <= 1'b0;
        end else if (w_wr_accept) begin
            r_wr_onehot <= w_dec_onehot;
            r_data_q    <= bus.data_writeReg;
            r_pending   <= 1'b1;
        end else begin
            r_wr_onehot <= '0;
            r_pending   <= 1'b0;
        end
    end

`ifdef REGFILE_WR_FORWARD_EN
    // Pending write address for the read bypass
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_wr_addr <= '0;
        end else if (w_wr_accept) begin
            r_wr_addr <= bus.ctrl_writeReg;
        end
    end
`endif

    // Write stage 2 commit and clear sweep; the sweep overrides a same-edge commit
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < int'(NUM_REGS); i++) begin
                if (r_pending && r_wr_onehot[i]) begin
                    r_regs[i] <= r_data_q;
                end
                if (w_sweep && (r_clr_cnt == ADDR_W'(i))) begin
                    r_regs[i] <= '0;
                end
            end
        end
    end

    // Combinational read ports with zero register and optional bypass
    always_comb begin
        w_rd_a = (bus.ctrl_readRegA == ADDR_W'(REG_ZERO)) ? '0 : r_regs[bus.ctrl_readRegA];
        w_rd_b = (bus.ctrl_readRegB == ADDR_W'(REG_ZERO)) ? '0 : r_regs[bus.ctrl_readRegB];
`ifdef REGFILE_WR_FORWARD_EN
        if (r_pending && (r_state == IDLE) && (bus.ctrl_readRegA == r_wr_addr) &&
            (bus.ctrl_readRegA != ADDR_W'(REG_ZERO))) begin
            w_rd_a = r_data_q;
        end
        if (r_pending && (r_state == IDLE) && (bus.ctrl_readRegB == r_wr_addr) &&
            (bus.ctrl_readRegB != ADDR_W'(REG_ZERO))) begin
            w_rd_b = r_data_q;
        end
`endif
    end

    assign bus.data_readRegA = w_rd_a;
    assign bus.data_readRegB = w_rd_b;
    assign bus.busy          = r_busy;
    assign bus.wr_onehot     = r_wr_onehot;

endmodule
